modexp_encrypt: RTL and testbench

- Sequential RSA encryption unit: computes cipher = msg^exp mod modulus using right-to-left square-and-multiply, one exponent bit per clock.
- Encrypt-side counterpart of the ALU's combinational decrypt operation, which uses a fixed private exponent.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy and picks up cipher on done.
- Start/busy/done handshake.

---
 rtl/modexp_encrypt_if.sv | 25 ++
 rtl/modexp_encrypt.sv | 142 ++++++++++++++
 tb/tb_modexp_encrypt.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/modexp_encrypt_if.sv
// Start/busy/done request-response bundle for the modexp_encrypt unit.
// The pipeline side uses master; the unit itself uses slave.
interface modexp_encrypt_if #(
   parameter int D_W = 32,
   parameter int E_W = 16
);
   logic           start;
   logic [D_W-1:0] msg;
   logic [E_W-1:0] exp;
   logic [D_W-1:0] modulus;
   logic           busy;
   logic           done;
   logic           err;
   logic [D_W-1:0] cipher;

   modport master (
      output start, msg, exp, modulus,
      input  busy, done, err, cipher
   );

   modport slave (
      input  start, msg, exp, modulus,
      output busy, done, err, cipher
   );
endinterface

// File: rtl/modexp_encrypt.sv
// RSA encrypt: cipher = msg^exp mod modulus, right-to-left square-and-multiply, one exponent bit per clock.
// Fixed E_W iterations by default; MODEXP_EARLY_EXIT_EN stops once the remaining exponent bits are zero.
module modexp_encrypt #(
   parameter int D_W = 32,
   parameter int E_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   modexp_encrypt_if.slave bus
);
   localparam int CNT_W = $clog2(E_W + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]       state_q,  state_d;
   logic [D_W-1:0]   msg_q,    msg_d;
   logic [E_W-1:0]   exp_q,    exp_d;
   logic [D_W-1:0]   n_q,      n_d;
   logic [D_W-1:0]   base_q,   base_d;
   logic [D_W-1:0]   acc_q,    acc_d;
   logic [E_W-1:0]   e_sh_q,   e_sh_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             done_q,   done_d;
   logic             err_q,    err_d;
   logic [D_W-1:0]   cipher_q, cipher_d;

   // Double-width operands so products are reduced before any truncation.
   logic [2*D_W-1:0] acc_w, base_w, n_w, msg_w;
   logic [D_W-1:0]   mul_red, sq_red, msg_red;
   logic             last_iter;

   always_comb begin
      acc_w   = {{D_W{1'b0}}, acc_q};
      base_w  = {{D_W{1'b0}}, base_q};
      n_w     = {{D_W{1'b0}}, n_q};
      msg_w   = {{D_W{1'b0}}, msg_q};
      mul_red = D_W'((acc_w * base_w) % n_w);
      sq_red  = D_W'((base_w * base_w) % n_w);
      msg_red = D_W'(msg_w % n_w);
`ifdef MODEXP_EARLY_EXIT_EN
      last_iter = (cnt_q == CNT_W'(E_W - 1)) || ((e_sh_q >> 1) == '0);
`else
      last_iter = (cnt_q == CNT_W'(E_W - 1));
`endif
   end

   always_comb begin
      state_d  = state_q;
      msg_d    = msg_q;
      exp_d    = exp_q;
      n_d      = n_q;
      base_d   = base_q;
      acc_d    = acc_q;
      e_sh_d   = e_sh_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      err_d    = err_q;
      cipher_d = cipher_q;

      case (state_q)
         S_IDLE: begin
            // done_q marks the first IDLE cycle, which still belongs to the finished op.
            if (bus.start && !done_q) begin
               msg_d   = bus.msg;
               exp_d   = bus.exp;
               n_d     = bus.modulus;
               err_d   = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (n_q == '0) begin
               err_d    = 1'b1;
               cipher_d = '0;
               state_d  = S_FIN;
            end else begin
               base_d  = msg_red;
               acc_d   = (n_q == D_W'(1)) ? '0 : D_W'(1);
               e_sh_d  = exp_q;
               cnt_d   = '0;
`ifdef MODEXP_EARLY_EXIT_EN
               state_d = (exp_q == '0) ? S_FIN : S_ITER;
`else
               state_d = S_ITER;
`endif
            end
         end
         S_ITER: begin
            if (e_sh_q[0]) begin
               acc_d = mul_red;
            end
            base_d = sq_red;
            e_sh_d = e_sh_q >> 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_iter) begin
               state_d = S_FIN;
            end
         end
         default: begin
            cipher_d = err_q ? '0 : acc_q;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         msg_q    <= '0;
         exp_q    <= '0;
         n_q      <= '0;
         base_q   <= '0;
         acc_q    <= '0;
         e_sh_q   <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cipher_q <= '0;
      end else begin
         state_q  <= state_d;
         msg_q    <= msg_d;
         exp_q    <= exp_d;
         n_q      <= n_d;
         base_q   <= base_d;
         acc_q    <= acc_d;
         e_sh_q   <= e_sh_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         cipher_q <= cipher_d;
      end
   end

   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = done_q;
   assign bus.err    = err_q;
   assign bus.cipher = cipher_q;
endmodule

// File: tb/tb_modexp_encrypt.sv
// Scoreboard bench for modexp_encrypt: directed vectors push expected results, a negedge monitor checks each done.
module tb_modexp_encrypt;
   logic clk;
   logic rst;
   int   cyc;
   int   tests;
   int   fails;
   int   done_cnt;
   int   busy_cnt;
   logic prev_done;

   typedef struct {
      logic [31:0] c;
      logic        e;
      int          lat;
      int          acc;
   } exp_t;
   exp_t sb[$];

   modexp_encrypt_if #(.D_W(32), .E_W(16)) bus ();

   modexp_encrypt #(.D_W(32), .E_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic int exp_lat(input logic [15:0] e, input logic [31:0] n);
      int bl;
      if (n == 0) return 2;
`ifdef MODEXP_EARLY_EXIT_EN
      if (e == 0) return 2;
      bl = 0;
      for (int i = 0; i < 16; i++) if (e[i]) bl = i + 1;
      return 2 + bl;
`else
      bl = int'(e[0]);
      return 18 + bl - bl;
`endif
   endfunction

   // Monitor: every done pulse pops one expectation.
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt  = 0;
         prev_done = 1'b0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (prev_done) chk("done_single_pulse", 1, 0);
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("cipher", {32'd0, bus.cipher}, {32'd0, x.c});
               chk("err", {63'd0, bus.err}, {63'd0, x.e});
               chk("latency", 64'(cyc - x.acc), 64'(x.lat));
               chk("busy_cycles", 64'(busy_cnt), 64'(x.lat));
            end
            busy_cnt = 0;
         end
         prev_done = bus.done;
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (!bus.busy && !bus.done) return;
         @(negedge clk);
      end
      chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic issue(input logic [31:0] m, input logic [15:0] e, input logic [31:0] n,
                        input logic [31:0] c, input logic er);
      exp_t x;
      wait_idle();
      bus.msg     = m;
      bus.exp     = e;
      bus.modulus = n;
      bus.start   = 1'b1;
      x.c   = c;
      x.e   = er;
      x.lat = exp_lat(e, n);
      x.acc = cyc + 1;
      sb.push_back(x);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.msg     = $urandom;
      bus.exp     = 16'($urandom);
      bus.modulus = $urandom;
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 300; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (i == 300) begin
         chk("drain_timeout", 64'(sb.size()), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_op(input logic [31:0] m, input logic [15:0] e, input logic [31:0] n,
                         input logic [31:0] c, input logic er);
      issue(m, e, n, c, er);
      drain();
   endtask

   initial begin
      int dc0;
      tests = 0; fails = 0; done_cnt = 0; busy_cnt = 0; prev_done = 1'b0; cyc = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.msg = '0; bus.exp = '0; bus.modulus = '0;
      #1;
      chk("rst_busy", {63'd0, bus.busy}, 0);
      chk("rst_done", {63'd0, bus.done}, 0);
      chk("rst_err", {63'd0, bus.err}, 0);
      chk("rst_cipher", {32'd0, bus.cipher}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_op(32'd65, 16'd17, 32'd3233, 32'd2790, 1'b0);
      run_op(32'd3298, 16'd17, 32'd3233, 32'd2790, 1'b0);
      run_op(32'd2, 16'd10, 32'd1000, 32'd24, 1'b0);
      repeat (10) @(negedge clk);
      chk("cipher_hold", {32'd0, bus.cipher}, 24);
      run_op(32'd5, 16'd0, 32'd7, 32'd1, 1'b0);
      run_op(32'd9, 16'd3, 32'd1, 32'd0, 1'b0);
      run_op(32'd7, 16'd13, 32'd11, 32'd2, 1'b0);
      run_op(32'd1234, 16'd5, 32'd0, 32'd0, 1'b1);
      repeat (5) @(negedge clk);
      chk("err_hold", {63'd0, bus.err}, 1);
      run_op(32'hFFFF_FFFF, 16'd3, 32'hFFFF_FFFB, 32'd64, 1'b0);
      run_op(32'hFFFF_FFFA, 16'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0);

      // Start pulses while busy and in the done cycle are ignored.
      dc0 = done_cnt;
      issue(32'd65, 16'd17, 32'd3233, 32'd2790, 1'b0);
      repeat (4) @(negedge clk);
      bus.msg = 32'd2; bus.exp = 16'd10; bus.modulus = 32'd1000; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (bus.done) break;
         @(negedge clk);
      end
      chk("done_seen_before_timeout", {63'd0, bus.done}, 1);
      bus.msg = 32'd2; bus.exp = 16'd10; bus.modulus = 32'd1000; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (30) @(negedge clk);
      chk("ignored_starts_done_count", 64'(done_cnt - dc0), 1);
      chk("ignored_starts_busy", {63'd0, bus.busy}, 0);
      run_op(32'd2, 16'd10, 32'd1000, 32'd24, 1'b0);

      // Abort mid-operation with reset; cipher is nonzero beforehand.
      run_op(32'hFFFF_FFFA, 16'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0);
      dc0 = done_cnt;
      issue(32'd65, 16'd17, 32'd3233, 32'd2790, 1'b0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", {63'd0, bus.busy}, 0);
      chk("abort_done", {63'd0, bus.done}, 0);
      chk("abort_err", {63'd0, bus.err}, 0);
      chk("abort_cipher", {32'd0, bus.cipher}, 0);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - dc0), 0);
      run_op(32'd65, 16'd17, 32'd3233, 32'd2790, 1'b0);
      run_op(32'd65, 16'd1, 32'd3233, 32'd65, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
